// File: rtl/ws_layer_sequencer.sv
// rtl/ws_layer_sequencer.sv - per-layer sequencer for the weight-stationary systolic array
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start_i, num_layers_i       run request and layer count (sampled in IDLE)
//   busy_o, done_o              run in progress, one-cycle end-of-run pulse
//   wt_rd_en_o, wt_rd_addr_o    weight buffer read (tile address = layer)
//   id_rd_en_o, id_rd_addr_o    input buffer read (vector address = layer)
//   id_rd_data_i                input vector, one cycle after the read strobe
//   id_wr_en_o, id_wr_addr_o    result write into input buffer (address = layer+1)
//   id_wr_data_o                saturated / ReLU'd results
//   load_en_o, acc_en_o         array weight-load and accumulate enables
//   data_o                      diagonally skewed array row inputs
//   acc_i                       array accumulator lanes (signed)
module ws_layer_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 64,
  parameter int NEURON_NUM = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  input  logic [ADDR_WIDTH-1:0]            num_layers_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             wt_rd_en_o,
  output logic [ADDR_WIDTH-1:0]            wt_rd_addr_o,
  output logic                             id_rd_en_o,
  output logic [ADDR_WIDTH-1:0]            id_rd_addr_o,
  input  logic [DATA_WIDTH*NEURON_NUM-1:0] id_rd_data_i,
  output logic                             id_wr_en_o,
  output logic [ADDR_WIDTH-1:0]            id_wr_addr_o,
  output logic [DATA_WIDTH*NEURON_NUM-1:0] id_wr_data_o,
  output logic                             load_en_o,
  output logic                             acc_en_o,
  output logic [DATA_WIDTH*NEURON_NUM-1:0] data_o,
  input  logic [ACC_WIDTH*NEURON_NUM-1:0]  acc_i
);

  localparam int VW        = DATA_WIDTH * NEURON_NUM;
  localparam int FEED_LAST = 2 * NEURON_NUM - 2;
  localparam int CNT_W     = $clog2(2 * NEURON_NUM);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_LOAD, S_FEED, S_CAPTURE, S_DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   layer;
  logic [ADDR_WIDTH-1:0]   num_q;
  logic [CNT_W-1:0]        cnt;
  logic [VW-1:0]           vec;
  logic [ADDR_WIDTH-1:0]   layer_nxt;
  logic                    is_last;

  assign layer_nxt = layer + ADDR_WIDTH'(1);
  assign is_last   = (layer_nxt == num_q);

  // Lane k carries its element only in feed step k; all other lanes are 0.
  function automatic logic [VW-1:0] skew(input logic [VW-1:0] v, input logic [CNT_W-1:0] c);
    logic [VW-1:0] r;
    r = '0;
    for (int k = 0; k < NEURON_NUM; k++)
      if (c == CNT_W'(k)) r[k*DATA_WIDTH +: DATA_WIDTH] = v[k*DATA_WIDTH +: DATA_WIDTH];
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat_relu(input logic signed [ACC_WIDTH-1:0] a,
                                                     input logic relu);
    logic [DATA_WIDTH-1:0] r;
    if (a > SAT_MAX)      r = SAT_MAX[DATA_WIDTH-1:0];
    else if (a < SAT_MIN) r = SAT_MIN[DATA_WIDTH-1:0];
    else                  r = a[DATA_WIDTH-1:0];
    if (relu && r[DATA_WIDTH-1]) r = '0;
    return r;
  endfunction

  // The accumulators are sampled during the CAPTURE cycle itself, which is
  // the cycle the buffer commits the write, so this path stays combinational.
  always_comb begin
    id_wr_data_o = '0;
    if (id_wr_en_o)
      for (int k = 0; k < NEURON_NUM; k++)
        id_wr_data_o[k*DATA_WIDTH +: DATA_WIDTH] =
          sat_relu(acc_i[k*ACC_WIDTH +: ACC_WIDTH], !is_last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      layer        <= '0;
      num_q        <= '0;
      cnt          <= '0;
      vec          <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      wt_rd_en_o   <= 1'b0;
      wt_rd_addr_o <= '0;
      id_rd_en_o   <= 1'b0;
      id_rd_addr_o <= '0;
      id_wr_en_o   <= 1'b0;
      id_wr_addr_o <= '0;
      load_en_o    <= 1'b0;
      acc_en_o     <= 1'b0;
      data_o       <= '0;
    end else begin
      // Outputs are registered: each branch sets what the next state drives.
      done_o       <= 1'b0;
      wt_rd_en_o   <= 1'b0;
      wt_rd_addr_o <= '0;
      id_rd_en_o   <= 1'b0;
      id_rd_addr_o <= '0;
      id_wr_en_o   <= 1'b0;
      id_wr_addr_o <= '0;
      load_en_o    <= 1'b0;
      acc_en_o     <= 1'b0;
      data_o       <= '0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            num_q <= num_layers_i;
            layer <= '0;
            if (num_layers_i == '0) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end else begin
              state      <= S_RD;
              busy_o     <= 1'b1;
              wt_rd_en_o <= 1'b1;
              id_rd_en_o <= 1'b1;
            end
          end
        end
        S_RD: begin
          state     <= S_LOAD;
          load_en_o <= 1'b1;
        end
        S_LOAD: begin
          // Read data is valid now; step 0 is driven straight from it.
          vec      <= id_rd_data_i;
          cnt      <= '0;
          state    <= S_FEED;
          acc_en_o <= 1'b1;
          data_o   <= skew(id_rd_data_i, '0);
        end
        S_FEED: begin
          if (cnt == CNT_W'(FEED_LAST)) begin
            cnt          <= '0;
            state        <= S_CAPTURE;
            id_wr_en_o   <= 1'b1;
            id_wr_addr_o <= layer_nxt;
          end else begin
            cnt      <= cnt + CNT_W'(1);
            acc_en_o <= 1'b1;
            data_o   <= skew(vec, cnt + CNT_W'(1));
          end
        end
        S_CAPTURE: begin
          if (is_last) begin
            state  <= S_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            layer        <= layer_nxt;
            state        <= S_RD;
            wt_rd_en_o   <= 1'b1;
            wt_rd_addr_o <= layer_nxt;
            id_rd_en_o   <= 1'b1;
            id_rd_addr_o <= layer_nxt;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws_layer_sequencer.sv
// tb/tb_ws_layer_sequencer.sv - self-checking bench for ws_layer_sequencer
module tb_ws_layer_sequencer;

  localparam int DW  = 16;
  localparam int AW  = 64;
  localparam int N   = 4;
  localparam int ADW = 4;
  localparam int PL  = 2 * N + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic [ADW-1:0]    num_layers_i;
  logic              busy_o, done_o;
  logic              wt_rd_en_o, id_rd_en_o, id_wr_en_o, load_en_o, acc_en_o;
  logic [ADW-1:0]    wt_rd_addr_o, id_rd_addr_o, id_wr_addr_o;
  logic [DW*N-1:0]   id_rd_data_i, id_wr_data_o, data_o;
  logic [AW*N-1:0]   acc_i;

  always #5 clk = ~clk;

  ws_layer_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NEURON_NUM(N), .ADDR_WIDTH(ADW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .num_layers_i(num_layers_i),
    .busy_o(busy_o), .done_o(done_o),
    .wt_rd_en_o(wt_rd_en_o), .wt_rd_addr_o(wt_rd_addr_o),
    .id_rd_en_o(id_rd_en_o), .id_rd_addr_o(id_rd_addr_o), .id_rd_data_i(id_rd_data_i),
    .id_wr_en_o(id_wr_en_o), .id_wr_addr_o(id_wr_addr_o), .id_wr_data_o(id_wr_data_o),
    .load_en_o(load_en_o), .acc_en_o(acc_en_o), .data_o(data_o), .acc_i(acc_i)
  );

  int total = 0;
  int bad   = 0;

  logic [DW*N-1:0] sim_buf [16];
  logic [DW*N-1:0] ref_buf [16];
  longint          acc_tab [16][N];

  task automatic chk(input string tag, input int c, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] lane_res(input longint a, input bit last);
    longint r;
    if (a > 32767)       r = 32767;
    else if (a < -32768) r = -32768;
    else                 r = a;
    if (!last && r < 0)  r = 0;
    return r[DW-1:0];
  endfunction

  function automatic longint rand_acc();
    longint t;
    case ($urandom_range(0, 3))
      0: t = longint'({$urandom, $urandom});
      1: t = longint'($urandom_range(0, 131071)) - 65536;
      2: t = longint'($urandom_range(0, 199)) - 100;
      default: begin
        case ($urandom_range(0, 5))
          0: t = 32767;
          1: t = 32768;
          2: t = -32768;
          3: t = -32769;
          4: t = 0;
          default: t = -1;
        endcase
      end
    endcase
    return t;
  endfunction

  task automatic randomize_data();
    for (int a = 0; a < 16; a++) begin
      sim_buf[a] = {$urandom, $urandom};
      for (int k = 0; k < N; k++) acc_tab[a][k] = rand_acc();
    end
  endtask

  // One run from the cycle start_i is raised (cycle 0). Expected behaviour
  // is derived from the layer/phase position: phase 0 read, 1 load,
  // 2..2N feed step (phase-2), 2N+1 capture; done in cycle n*PL+1.
  task automatic run(input int n, input int pulse_at, input int rst_at, input bit done_start);
    int              last_c, layer, phase;
    bit              in_run, rd_pend;
    logic [ADW-1:0]  rd_addr;
    logic            e_busy, e_done, e_rd, e_wr, e_load, e_acc;
    logic [ADW-1:0]  e_rd_addr, e_wr_addr;
    logic [DW*N-1:0] e_data, e_wdata, v;
    last_c  = PL * n + 3;
    rd_pend = 1'b0;
    rd_addr = '0;
    for (int a = 0; a < 16; a++) ref_buf[a] = sim_buf[a];
    for (int c = 0; c <= last_c; c++) begin
      @(posedge clk); #1;
      in_run = (c >= 1) && (c <= PL * n);
      layer  = in_run ? (c - 1) / PL : 0;
      phase  = in_run ? (c - 1) % PL : 0;
      rst     = (c == rst_at);
      start_i = (c == 0) || (c == pulse_at) ||
                (done_start && (c == PL * n + 1 || c == PL * n + 2));
      num_layers_i = (c == 0 || (done_start && c == PL * n + 2)) ? ADW'(n) : ADW'($urandom);
      id_rd_data_i = rd_pend ? sim_buf[rd_addr] : {$urandom, $urandom};
      acc_i = '0;
      if (in_run)
        for (int k = 0; k < N; k++) acc_i[k*AW +: AW] = acc_tab[layer][k];
      @(negedge clk);
      rd_pend = id_rd_en_o;
      rd_addr = id_rd_addr_o;
      if (id_wr_en_o) sim_buf[id_wr_addr_o] = id_wr_data_o;

      e_busy = 0; e_done = 0; e_rd = 0; e_wr = 0; e_load = 0; e_acc = 0;
      e_rd_addr = '0; e_wr_addr = '0; e_data = '0; e_wdata = '0;
      if (rst_at >= 0 && c > rst_at) begin
        // aborted: everything stays quiet
      end else if (in_run) begin
        e_busy = 1;
        v = ref_buf[layer];
        if (phase == 0) begin e_rd = 1; e_rd_addr = ADW'(layer); end
        if (phase == 1) e_load = 1;
        if (phase >= 2 && phase <= 2 * N) begin
          e_acc = 1;
          if (phase - 2 < N) e_data[(phase-2)*DW +: DW] = v[(phase-2)*DW +: DW];
        end
        if (phase == PL - 1) begin
          e_wr = 1;
          e_wr_addr = ADW'(layer + 1);
          for (int k = 0; k < N; k++)
            e_wdata[k*DW +: DW] = lane_res(acc_tab[layer][k], layer == n - 1);
          ref_buf[layer + 1] = e_wdata;
        end
      end else if (c == PL * n + 1) begin
        e_done = 1;
      end else if (done_start && c == PL * n + 3) begin
        e_busy = 1; e_rd = 1;
      end

      chk("busy", c, 64'(busy_o), 64'(e_busy));
      chk("done", c, 64'(done_o), 64'(e_done));
      chk("wt_rd_en", c, 64'(wt_rd_en_o), 64'(e_rd));
      chk("wt_rd_addr", c, 64'(wt_rd_addr_o), 64'(e_rd_addr));
      chk("id_rd_en", c, 64'(id_rd_en_o), 64'(e_rd));
      chk("id_rd_addr", c, 64'(id_rd_addr_o), 64'(e_rd_addr));
      chk("id_wr_en", c, 64'(id_wr_en_o), 64'(e_wr));
      chk("id_wr_addr", c, 64'(id_wr_addr_o), 64'(e_wr_addr));
      chk("id_wr_data", c, 64'(id_wr_data_o), 64'(e_wdata));
      chk("load_en", c, 64'(load_en_o), 64'(e_load));
      chk("acc_en", c, 64'(acc_en_o), 64'(e_acc));
      chk("data_o", c, 64'(data_o), 64'(e_data));
    end
    @(posedge clk); #1;
    start_i = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    rst = 1; start_i = 0; num_layers_i = '0; id_rd_data_i = '0; acc_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_busy", 0, 64'(busy_o), 64'd0);
    chk("rst_done", 0, 64'(done_o), 64'd0);
    chk("rst_strobes", 0, 64'({wt_rd_en_o, id_rd_en_o, id_wr_en_o, load_en_o, acc_en_o}), 64'd0);
    chk("rst_data", 0, 64'(data_o), 64'd0);

    // single layer: skew {1,2,3,4} and last-layer saturation, no ReLU
    randomize_data();
    sim_buf[0] = 64'h0004_0003_0002_0001;
    acc_tab[0][0] = 40000; acc_tab[0][1] = -40000; acc_tab[0][2] = -5; acc_tab[0][3] = 7;
    run(1, -1, -1, 1'b0);
    chk("single_result", 0, 64'(sim_buf[1]), 64'h0007_fffb_8000_7fff);

    // hidden layer: same accumulators, saturate then ReLU
    randomize_data();
    acc_tab[0][0] = 40000; acc_tab[0][1] = -40000; acc_tab[0][2] = -5; acc_tab[0][3] = 7;
    run(2, -1, -1, 1'b0);
    chk("hidden_result", 0, 64'(ref_buf[1]), 64'h0007_0000_0000_7fff);

    // three layers, stray start in cycle 5, start held through done
    randomize_data();
    run(3, 5, -1, 1'b1);

    // zero layers
    run(0, -1, -1, 1'b0);

    // reset in cycle 6 of a single-layer run
    randomize_data();
    run(1, -1, 6, 1'b0);

    // random layer counts, including the maximum
    for (int i = 0; i < 6; i++) begin
      randomize_data();
      run($urandom_range(1, 5), $urandom_range(2, 9), -1, 1'($urandom_range(0, 1)));
    end
    randomize_data();
    run(15, -1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ws_layer_sequencer.md
# ws_layer_sequencer

Layer sequencer for the weight-stationary 4x4 systolic array in the FFN datapath. For each layer it:
- reads a weight tile and an input vector from the two register-file buffers,
- loads the weights into the array and feeds the input vector diagonally skewed,
- captures the accumulators and writes the saturated (and, for hidden layers, ReLU'd) results back into the input buffer as the next layer's input.

It runs a start/done handshake for a configurable number of layers. It is the only master of the array enables and the buffer ports during a run.

## Interface
Parameters:
- DATA_WIDTH, 16, width of one activation/weight element
- ACC_WIDTH, 64, width of one array accumulator lane (signed)
- NEURON_NUM, 4, array dimension / vector length
- ADDR_WIDTH, 4, buffer address width; max layers = 2^ADDR_WIDTH-1

Ports:
- Clock and reset (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
  - clk  in  1  clock
  - rst  in  1  synchronous reset, active high
- Run control:
  - start_i  in  1  begin a run (sampled only in IDLE)
  - num_layers_i  in  ADDR_WIDTH  layer count, latched on accepted start
  - busy_o  out  1  run in progress
  - done_o  out  1  one-cycle pulse at end of run
- Weight buffer read:
  - wt_rd_en_o  out  1  weight buffer read strobe
  - wt_rd_addr_o  out  ADDR_WIDTH  weight tile address = layer index
- Input buffer read:
  - id_rd_en_o  out  1  input buffer read strobe
  - id_rd_addr_o  out  ADDR_WIDTH  input vector address = layer index
  - id_rd_data_i  in  DATA_WIDTH*NEURON_NUM  input vector; valid 1 cycle after read strobe
- Input buffer write:
  - id_wr_en_o  out  1  result write strobe
  - id_wr_addr_o  out  ADDR_WIDTH  result address = layer index + 1
  - id_wr_data_o  out  DATA_WIDTH*NEURON_NUM  saturated/activated results
- Systolic array:
  - load_en_o  out  1  array weight load enable
  - acc_en_o  out  1  array accumulate enable
  - data_o  out  DATA_WIDTH*NEURON_NUM  skewed array row inputs; lane k = bits [DATA_WIDTH*(k+1)-1 -: DATA_WIDTH]
  - acc_i  in  ACC_WIDTH*NEURON_NUM  array accumulator outputs

## Operation
- States and transitions:
  - IDLE: on start_i, latch num_layers_i and set layer index L=0. If num_layers_i==0, go to DONE; else go to RD.
  - RD (1 cycle):
    - wt_rd_en_o=1 and id_rd_en_o=1.
    - wt_rd_addr_o=L and id_rd_addr_o=L.
  - LOAD (1 cycle):
    - load_en_o=1; the weight buffer data drives the array directly.
    - Latch id_rd_data_i into an internal vector register V.
    - Go to FEED with cnt=0.
  - FEED (2*NEURON_NUM-1 cycles, cnt 0..2N-2):
    - acc_en_o=1.
    - data_o lane k = V[k] when cnt==k, else 0.
  - CAPTURE (1 cycle):
    - acc_en_o=0; sample acc_i.
    - id_wr_en_o=1, id_wr_addr_o=L+1, id_wr_data_o = per-lane result.
    - If L+1==latched count, go to DONE; else L<=L+1 and go to RD.
  - DONE (1 cycle): done_o=1, busy_o=0, then IDLE.
- Per-lane result:
  - Signed saturate acc lane to [-2^(DW-1), 2^(DW-1)-1].
  - Then ReLU (negative -> 0) for every layer except the last, where the result is written unmodified.
- All strobes and enables are 0 outside the states listed. data_o=0 outside FEED.
- start_i is ignored while busy. num_layers_i changes mid-run have no effect.

## Timing
- Reset: all outputs 0, state IDLE, L=0, cnt=0. Reset mid-run aborts immediately: no further write or done pulse.
- Start accepted at edge of cycle 0 → busy_o=1 from cycle 1.
- Per layer: 2*NEURON_NUM+2 cycles (10 at N=4).
- done_o is asserted in cycle num_layers*(2N+2)+1. For num_layers=0, done_o is asserted in cycle 1 with busy_o never high and no buffer access.
- Buffer read latency is exactly 1 cycle; no stall support.
- Max num_layers = 2^ADDR_WIDTH-1, so L+1 never wraps.
- start_i asserted in the same cycle as done_o is ignored (state not IDLE). It is accepted the next cycle.

## Test plan
- **Single layer:** num_layers=1, start → RD cycle 1, LOAD 2, FEED 3–9, CAPTURE 10 with id_wr_addr_o=1, done_o in cycle 11 only.
- **Skew:** V={1,2,3,4} → data_o lane k nonzero only at FEED cnt=k with value k+1. All lanes 0 at cnt 4–6.
- **Saturation and ReLU, last layer:** acc_i lanes {40000, -40000, -5, 7}, single layer → id_wr_data_o {32767, -32768, -5, 7}.
- **Saturation and ReLU, hidden layer:** same acc_i lanes on layer 0 of a 2-layer run → {32767, 0, 0, 7}.
- **Three layers:** read addresses 0,1,2; write addresses 1,2,3; done_o in cycle 31; start_i pulsed at cycle 5 ignored.
- **Zero layers and reset:**
  - num_layers=0 → done_o in cycle 1, no strobes.
  - rst at cycle 6 of a 1-layer run → all outputs 0 next cycle; no id_wr_en_o or done_o afterwards.
